// File: rtl/sw_pkg.sv
// Shared widths, field offsets and board defaults for the switch conditioning path.
package sw_pkg;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned SEL_W          = 2;
    localparam int unsigned SW_W           = DATA_W + SEL_W;
    localparam int unsigned SEL_LSB        = 8;
    localparam int unsigned DATA_LSB       = 0;
    localparam int unsigned DEF_SAMPLE_DIV = 1000;
    localparam int unsigned DEF_STABLE     = 8;

    // Switch word as seen by the key-select mux.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } sw_word_t;

    // Bits needed to count 0..max_count-1, never less than one.
    function automatic int unsigned ctr_w(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, tick-gated stability counter, output flop and edge pulses.
module debounce_bit
    import sw_pkg::*;
#(
    parameter int unsigned STABLE    = DEF_STABLE,
    parameter logic        RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic upd_c
);

    localparam int unsigned CW = $clog2(STABLE) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_next;

    // Any matching sample restarts the count, so short bounces never propagate.
    always_comb begin
        cnt_next   = cnt;
        level_next = level;
        upd_c      = 1'b0;
        if (tick) begin
            if (sync2 == level) begin
                cnt_next = '0;
            end else if (cnt == CW'(STABLE - 1)) begin
                cnt_next   = '0;
                level_next = sync2;
                upd_c      = 1'b1;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= RESET_BIT;
            sync2 <= RESET_BIT;
            level <= RESET_BIT;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            level <= level_next;
            cnt   <= cnt_next;
            rise  <= upd_c & sync2;
            fall  <= upd_c & ~sync2;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Conditions raw board switches into clean mux a/s inputs and flags changes of the debounced word.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned      WIDTH      = SW_W,
    parameter int unsigned      SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int unsigned      STABLE     = DEF_STABLE,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg
);

    localparam int unsigned PW = ctr_w(SAMPLE_DIV);

    logic [PW-1:0]    presc;
    logic             tick_c;
    logic [WIDTH-1:0] upd_c;

    // Shared sample prescaler; with SAMPLE_DIV of 1 it sits at zero and ticks every cycle.
    assign tick_c = (presc == PW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        debounce_bit #(
            .STABLE    (STABLE),
            .RESET_BIT (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick_c),
            .raw   (sw_in[i]),
            .level (sw_out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .upd_c (upd_c[i])
        );
    end

    // Any bit updating this edge means the registered word changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chg <= 1'b0;
        end else begin
            chg <= |upd_c;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: reset, clean steps, bounce rejection, prescaler timing, mid-count reset, mux hookup.
module tb_sw_debounce;
    import sw_pkg::*;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out, rise, fall;
    logic         chg;
    logic [W-1:0] sw_in_p = '0;
    logic [W-1:0] sw_out_p, rise_p, fall_p;
    logic         chg_p;

    int           vec_cnt = 0;
    int           err_cnt = 0;
    logic [W-1:0] model_out = '0;
    int unsigned  pc = 0;
    logic [1:0]   mux_y;

    sw_debounce #(.WIDTH(W), .SAMPLE_DIV(1), .STABLE(4), .RESET_VAL(10'h000)) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
        .sw_out(sw_out), .rise(rise), .fall(fall), .chg(chg)
    );

    sw_debounce #(.WIDTH(W), .SAMPLE_DIV(5), .STABLE(3), .RESET_VAL(10'h000)) dut_p (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in_p),
        .sw_out(sw_out_p), .rise(rise_p), .fall(fall_p), .chg(chg_p)
    );

    always #5 clk = ~clk;

    // Reference phase of a divide-by-5 sample prescaler restarted by reset.
    always @(posedge clk) begin
        if (!rst_n) pc <= 0;
        else        pc <= (pc == 4) ? 0 : pc + 1;
    end

    // Key-select mux: picks a 2-bit field of the data byte by the select bits.
    assign mux_y = 2'(sw_out[DATA_LSB +: DATA_W] >> (2 * sw_out[SEL_LSB +: SEL_W]));

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_in = 10'h3FF;
        for (int k = 1; k <= 3; k++) begin
            wait_edges(1);
            vec_cnt++;
            if (sw_out !== 10'h000) begin
                err_cnt++;
                $display("FAIL reset_out edge %0d: got %h want 000", k, sw_out);
            end
            vec_cnt++;
            if ({rise, fall, chg} !== '0) begin
                err_cnt++;
                $display("FAIL reset_pulse edge %0d: rise %h fall %h chg %b want 0", k, rise, fall, chg);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            wait_edges(1);
            vec_cnt++;
            if (sw_out !== ((k >= 6) ? 10'h3FF : 10'h000)) begin
                err_cnt++;
                $display("FAIL reset_release_out edge %0d: got %h", k, sw_out);
            end
            vec_cnt++;
            if ({rise, chg} !== ((k == 6) ? {10'h3FF, 1'b1} : 11'h0)) begin
                err_cnt++;
                $display("FAIL reset_release_pulse edge %0d: rise %h chg %b", k, rise, chg);
            end
        end
        model_out = 10'h3FF;
    endtask

    task automatic test_clean_step();
        logic [W-1:0] vals[2] = '{10'h000, 10'h2A5};
        logic [W-1:0] prev, nxt, exp_o, exp_r, exp_f;
        logic         exp_c;
        for (int s = 0; s < 2; s++) begin
            prev  = model_out;
            nxt   = vals[s];
            sw_in = nxt;
            for (int k = 1; k <= 7; k++) begin
                wait_edges(1);
                exp_o = (k >= 6) ? nxt : prev;
                exp_r = (k == 6) ? (nxt & ~prev) : '0;
                exp_f = (k == 6) ? (~nxt & prev) : '0;
                exp_c = (k == 6);
                vec_cnt++;
                if (sw_out !== exp_o) begin
                    err_cnt++;
                    $display("FAIL step%0d_out edge %0d: got %h want %h", s, k, sw_out, exp_o);
                end
                vec_cnt++;
                if ({rise, fall, chg} !== {exp_r, exp_f, exp_c}) begin
                    err_cnt++;
                    $display("FAIL step%0d_pulse edge %0d: rise %h fall %h chg %b want %h %h %b",
                             s, k, rise, fall, chg, exp_r, exp_f, exp_c);
                end
            end
            model_out = nxt;
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] nxt;
        // Toggling select bit 8, then settling back low: nothing may reach the output.
        for (int i = 0; i < 22; i++) begin
            sw_in    = model_out;
            sw_in[8] = (i < 12) ? ~i[0] : 1'b0;
            wait_edges(1);
            vec_cnt++;
            if ({sw_out, rise, fall, chg} !== {model_out, 21'h0}) begin
                err_cnt++;
                $display("FAIL bounce_low cycle %0d: out %h rise %h fall %h chg %b", i, sw_out, rise, fall, chg);
            end
        end
        for (int i = 0; i < 12; i++) begin
            sw_in[8] = ~i[0];
            wait_edges(1);
            vec_cnt++;
            if ({sw_out, chg} !== {model_out, 1'b0}) begin
                err_cnt++;
                $display("FAIL bounce_toggle cycle %0d: out %h chg %b", i, sw_out, chg);
            end
        end
        nxt      = model_out | 10'h100;
        sw_in[8] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            wait_edges(1);
            vec_cnt++;
            if (sw_out !== ((k >= 6) ? nxt : model_out)) begin
                err_cnt++;
                $display("FAIL bounce_high_out edge %0d: got %h", k, sw_out);
            end
            vec_cnt++;
            if ({rise, fall, chg} !== ((k == 6) ? {10'h100, 10'h000, 1'b1} : 21'h0)) begin
                err_cnt++;
                $display("FAIL bounce_high_pulse edge %0d: rise %h fall %h chg %b", k, rise, fall, chg);
            end
        end
        model_out = nxt;
    endtask

    task automatic test_prescaler();
        int i;
        // Step just after phase 3: the first tick lands before the sample is synchronised.
        for (i = 0; i < 10 && pc != 3; i++) wait_edges(1);
        vec_cnt++;
        if (pc != 3) begin
            err_cnt++;
            $display("FAIL presc_align: phase %0d want 3", pc);
        end
        sw_in_p = 10'h001;
        for (int k = 1; k <= 20; k++) begin
            wait_edges(1);
            vec_cnt++;
            if (sw_out_p !== ((k >= 17) ? 10'h001 : 10'h000)) begin
                err_cnt++;
                $display("FAIL presc_out edge %0d: got %h", k, sw_out_p);
            end
            vec_cnt++;
            if ({rise_p, chg_p} !== ((k == 17) ? {10'h001, 1'b1} : 11'h0)) begin
                err_cnt++;
                $display("FAIL presc_pulse edge %0d: rise %h chg %b", k, rise_p, chg_p);
            end
        end
    endtask

    task automatic test_mid_reset();
        sw_in = 10'h0FF;
        wait_edges(2);
        rst_n = 1'b0;
        wait_edges(1);
        vec_cnt++;
        if ({sw_out, rise, fall, chg} !== 31'h0) begin
            err_cnt++;
            $display("FAIL midreset_state: out %h rise %h fall %h chg %b want 0", sw_out, rise, fall, chg);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            wait_edges(1);
            vec_cnt++;
            if (sw_out !== ((k >= 6) ? 10'h0FF : 10'h000)) begin
                err_cnt++;
                $display("FAIL midreset_out edge %0d: got %h", k, sw_out);
            end
            vec_cnt++;
            if ({rise, fall, chg} !== ((k == 6) ? {10'h0FF, 10'h000, 1'b1} : 21'h0)) begin
                err_cnt++;
                $display("FAIL midreset_pulse edge %0d: rise %h fall %h chg %b", k, rise, fall, chg);
            end
        end
        model_out = 10'h0FF;
    endtask

    task automatic test_mux();
        logic [W-1:0] steps[2]   = '{10'h0E4, 10'h3E4};
        logic [1:0]   before_y[2] = '{2'b11, 2'b00};
        logic [1:0]   after_y[2]  = '{2'b00, 2'b11};
        for (int s = 0; s < 2; s++) begin
            sw_in = steps[s];
            for (int k = 1; k <= 6; k++) begin
                wait_edges(1);
                vec_cnt++;
                if (mux_y !== ((k == 6) ? after_y[s] : before_y[s])) begin
                    err_cnt++;
                    $display("FAIL mux%0d_y edge %0d: got %b", s, k, mux_y);
                end
            end
            vec_cnt++;
            if (sw_out !== steps[s]) begin
                err_cnt++;
                $display("FAIL mux%0d_out: got %h want %h", s, sw_out, steps[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_prescaler();
        test_mid_reset();
        test_mux();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
